ps2_hex_key_tx: RTL and testbench
=================================

Name: ps2_hex_key_tx

Overview:
- Keyboard-side PS/2 transmitter. Takes a 4-bit hex value and emits the matching set-1 scan code (make, then optionally break) as device-to-host PS/2 frames.
- Provides the producing end of the scan-code path that feeds the keypad-to-7-segment display path. Used for loopback test and for a keypad emulator.
- Drives open-drain PS/2 clock/data as release-enables (1 = released/high, 0 = pull low).

Parameters:
- CLK_DIV, 4, system clocks per half PS/2 bit period (>=2).
- SEND_BREAK, 1, 1 = send break code (make|8'h80) after make; 0 = make only.
- GAP_CYCLES, 8, idle system clocks (both lines released) between make and break frames (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hex_in  in  4  hex key value to send
- valid  in  1  request; accepted when valid && ready
- ready  out  1  high only in IDLE with host not inhibiting
- ps2_clk_i  in  1  sensed PS/2 clock line (host inhibit detect)
- ps2_clk_o  out  1  PS/2 clock drive, 1 = release
- ps2_data_o  out  1  PS/2 data drive, 1 = release
- code_out  out  8  scan code of the frame in flight / last sent
- done  out  1  one-cycle pulse when the full transaction completes
- abort  out  1  one-cycle pulse when a transaction is dropped on host inhibit

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-low on rst_n.
- Reset values: ps2_clk_o=1, ps2_data_o=1, ready=0 until the first cycle after deassert, code_out=8'h00, done=0, abort=0, state IDLE, sync flops=1.
- Reset mid-frame: lines release immediately and the transaction is lost; no done or abort pulse.
- Host inhibit sync: ps2_clk_i passes through a 2-flop synchronizer. Inhibit = synced value 0.
- Make-code map (hex value: code):
  - 0: 0B; 1: 02; 2: 03; 3: 04; 4: 05; 5: 06; 6: 07; 7: 08
  - 8: 09; 9: 0A; A: 1E; B: 30; C: 2E; D: 20; E: 12; F: 21
  - All 16 values are mapped; there is no default case.
- Break code = make | 8'h80.
- States: IDLE, FRAME, GAP, DONE.
- IDLE: ready = ~inhibit. On valid && ready:
  - latch the mapped make code into code_out and the shifter;
  - reset bit_idx=0 and phase counter;
  - set phase=HIGH; go to FRAME next cycle.
  - valid while !ready is ignored and not queued.
- FRAME: 11 bits, index 0..10, sent as start 0, data[0..7] LSB first, odd parity (XNOR-reduce of data), stop 1.
  - Each bit lasts 2*CLK_DIV cycles.
  - ps2_data_o is updated on the first cycle of the bit and held for the whole bit.
  - ps2_clk_o=1 for the first CLK_DIV cycles, then 0 for CLK_DIV cycles.
  - One frame = 22*CLK_DIV cycles.
- Frame completion: after the low half of bit 10, release both lines.
  - If SEND_BREAK=1 and the make frame just finished: go to GAP, load the break code into code_out.
  - Otherwise go to DONE.
- GAP: GAP_CYCLES cycles with both lines released, then FRAME with the break code.
- DONE: pulse done for 1 cycle, then IDLE. ready rises the cycle after done if no inhibit.
- Host inhibit during FRAME: if inhibit is sampled during any high-half cycle of bits 0..9:
  - release both lines next cycle;
  - pulse abort for 1 cycle; go to IDLE.
  - The remaining frames of the transaction are dropped.
- Host inhibit in other states: ignored during low halves and during bit 10. Ignored in GAP; the break frame still starts, and the FRAME rule applies from then on.
- Back-to-back requests: minimum spacing between requests is 1 IDLE cycle (the cycle after done).
- Transaction latency (accept to done):
  - 1 + 22*CLK_DIV + 1 cycles with SEND_BREAK=0;
  - 1 + 44*CLK_DIV + GAP_CYCLES + 1 cycles with SEND_BREAK=1.

Test Plan:
- Reset, then hold rst_n=1 with ps2_clk_i=1 -> ps2_clk_o=ps2_data_o=1, done=abort=0, ready=1 from the 2nd cycle after deassert.
- CLK_DIV=4, SEND_BREAK=1, GAP=8, hex_in=5 -> two frames:
  - make: code_out=06, data bits 0,0110 0000,1,1 (start, LSB-first data, parity 1, stop);
  - break: code_out=86, bits 0,0110 0001,0,1;
  - 8 released cycles between frames; done exactly 186 cycles after accept.
- SEND_BREAK=0, hex_in=A then hex_in=0 back-to-back -> frames 1E (parity 1) and 0B (parity 0), each 88 cycles; one done per request; valid during busy is ignored.
- Sweep all 16 hex values -> decoded make codes match the map; break = make|80; parity odd in every frame.
- Pull ps2_clk_i low during the high half of bit 4 -> abort pulses within 3 cycles (2-flop synchronizer plus 1-cycle release). Lines release, no done, ready=0 while inhibit is held and 1 after release.
- Assert rst_n=0 mid-frame (bit 6) -> lines release asynchronously the same cycle; after deassert a new request sends a complete, correct frame.

Source files
------------

// File: rtl/ps2_hex_key_tx.sv
// Keyboard-side PS/2 transmitter: turns a hex key value into its set-1 make
// (and optional break) scan code and sends it as device-to-host frames.
module ps2_hex_key_tx #(
    parameter int CLK_DIV    = 4,
    parameter bit SEND_BREAK = 1'b1,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hex_in,
    input  logic       valid,
    output logic       ready,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic [7:0] code_out,
    output logic       done,
    output logic       abort
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             phase_hi_q, phase_hi_d;
    logic             is_break_q, is_break_d;
    logic [7:0]       code_q, code_d;
    logic             sync1_q, sync2_q;
    logic             ready_q, ready_d;
    logic             clk_o_q, clk_o_d;
    logic             data_o_q, data_o_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             inhibit;

    function automatic logic [7:0] make_code(input logic [3:0] hex);
        logic [7:0] code;
        case (hex)
            4'h0: code = 8'h0B;
            4'h1: code = 8'h02;
            4'h2: code = 8'h03;
            4'h3: code = 8'h04;
            4'h4: code = 8'h05;
            4'h5: code = 8'h06;
            4'h6: code = 8'h07;
            4'h7: code = 8'h08;
            4'h8: code = 8'h09;
            4'h9: code = 8'h0A;
            4'hA: code = 8'h1E;
            4'hB: code = 8'h30;
            4'hC: code = 8'h2E;
            4'hD: code = 8'h20;
            4'hE: code = 8'h12;
            4'hF: code = 8'h21;
        endcase
        return code;
    endfunction

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame layout in send order: start, data LSB first, parity, stop.
    function automatic logic frame_bit(input logic [7:0] code, input logic [3:0] idx);
        logic [10:0] frame;
        frame = {1'b1, odd_parity(code), code, 1'b0};
        return frame[idx];
    endfunction

    assign inhibit = ~sync2_q;

    // Two-flop synchronizer for the sensed PS/2 clock line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ps2_clk_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic; line drives are derived from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        bit_idx_d  = bit_idx_q;
        phase_hi_d = phase_hi_q;
        is_break_d = is_break_q;
        code_d     = code_q;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid && ready_q) begin
                    code_d     = make_code(hex_in);
                    cnt_d      = {CNT_W{1'b0}};
                    bit_idx_d  = 4'd0;
                    phase_hi_d = 1'b1;
                    is_break_d = 1'b0;
                    state_d    = ST_FRAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRAME: begin
                // The host may only cut a frame during a high half before the stop bit.
                if (phase_hi_q && (bit_idx_q <= 4'd9) && inhibit) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (phase_hi_q) begin
                        phase_hi_d = 1'b0;
                    end else if (bit_idx_q == 4'd10) begin
                        if (SEND_BREAK && !is_break_q) begin
                            state_d    = ST_GAP;
                            gap_d      = {GAP_W{1'b0}};
                            is_break_d = 1'b1;
                            code_d     = code_q | 8'h80;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        bit_idx_d  = bit_idx_q + 4'd1;
                        phase_hi_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d    = ST_FRAME;
                    cnt_d      = {CNT_W{1'b0}};
                    bit_idx_d  = 4'd0;
                    phase_hi_d = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d  = (state_d == ST_IDLE) && !inhibit;
        clk_o_d  = (state_d == ST_FRAME) ? phase_hi_d : 1'b1;
        data_o_d = (state_d == ST_FRAME) ? frame_bit(code_d, bit_idx_d) : 1'b1;
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            gap_q      <= {GAP_W{1'b0}};
            bit_idx_q  <= 4'd0;
            phase_hi_q <= 1'b1;
            is_break_q <= 1'b0;
            code_q     <= 8'h00;
            ready_q    <= 1'b0;
            clk_o_q    <= 1'b1;
            data_o_q   <= 1'b1;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            bit_idx_q  <= bit_idx_d;
            phase_hi_q <= phase_hi_d;
            is_break_q <= is_break_d;
            code_q     <= code_d;
            ready_q    <= ready_d;
            clk_o_q    <= clk_o_d;
            data_o_q   <= data_o_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign ready      = ready_q;
    assign ps2_clk_o  = clk_o_q;
    assign ps2_data_o = data_o_q;
    assign code_out   = code_q;
    assign done       = done_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_ps2_hex_key_tx.sv
// Bench for ps2_hex_key_tx: one instance sends make+break, one sends make only;
// captured line activity is decoded the way a host would and compared to the scan-code table.
module tb_ps2_hex_key_tx;

    localparam int C = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] hex_in;
    logic       valid_b, valid_m;
    logic       ps2_clk_i;
    logic       b_ready, b_clk, b_data, b_done, b_abort;
    logic       m_ready, m_clk, m_data, m_done, m_abort;
    logic [7:0] b_code, m_code;

    always #5 clk = ~clk;

    ps2_hex_key_tx #(.CLK_DIV(C), .SEND_BREAK(1'b1), .GAP_CYCLES(G)) dut_b (
        .clk(clk), .rst_n(rst_n), .hex_in(hex_in), .valid(valid_b), .ready(b_ready),
        .ps2_clk_i(ps2_clk_i), .ps2_clk_o(b_clk), .ps2_data_o(b_data),
        .code_out(b_code), .done(b_done), .abort(b_abort));

    ps2_hex_key_tx #(.CLK_DIV(C), .SEND_BREAK(1'b0), .GAP_CYCLES(G)) dut_m (
        .clk(clk), .rst_n(rst_n), .hex_in(hex_in), .valid(valid_m), .ready(m_ready),
        .ps2_clk_i(ps2_clk_i), .ps2_clk_o(m_clk), .ps2_data_o(m_data),
        .code_out(m_code), .done(m_done), .abort(m_abort));

    int checks = 0;
    int failures = 0;

    logic [7:0] make_tab [16] = '{8'h0B, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                                  8'h09, 8'h0A, 8'h1E, 8'h30, 8'h2E, 8'h20, 8'h12, 8'h21};

    logic       sel_m = 1'b0;
    logic       t_clk[$], t_data[$], t_done[$], t_abort[$];
    logic [7:0] t_code[$];

    function automatic logic o_ready(); return sel_m ? m_ready : b_ready; endfunction
    function automatic logic o_clk();   return sel_m ? m_clk   : b_clk;   endfunction
    function automatic logic o_data();  return sel_m ? m_data  : b_data;  endfunction
    function automatic logic o_done();  return sel_m ? m_done  : b_done;  endfunction
    function automatic logic o_abort(); return sel_m ? m_abort : b_abort; endfunction
    function automatic logic [7:0] o_code(); return sel_m ? m_code : b_code; endfunction

    // Expected bits in time order: start 0, data LSB first, parity making the ones count odd, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] code);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = code[i];
        f[9]  = (($countones(code) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Issue one request and record one sample per cycle until done/abort, reset point or budget.
    task automatic run_txn(input logic [3:0] hx, input int poke_at, input int inhib_at, input int rst_at);
        int n;
        t_clk.delete(); t_data.delete(); t_done.delete(); t_abort.delete(); t_code.delete();
        n = 0;
        while (!o_ready() && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready()) begin
            checks++; failures++;
            $display("FAIL ready_wait: ready=%b required=1 within 50 cycles", o_ready());
            return;
        end
        hex_in = hx;
        if (sel_m) valid_m = 1'b1; else valid_b = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin valid_b = 1'b0; valid_m = 1'b0; end
            t_clk.push_back(o_clk());
            t_data.push_back(o_data());
            t_done.push_back(o_done());
            t_abort.push_back(o_abort());
            t_code.push_back(o_code());
            if (o_done() || o_abort()) break;
            if (k == poke_at) begin
                hex_in = hx ^ 4'hF;
                if (sel_m) valid_m = 1'b1; else valid_b = 1'b1;
            end
            if (k == poke_at + 3) begin valid_b = 1'b0; valid_m = 1'b0; end
            if (k == inhib_at) ps2_clk_i = 1'b0;
            if (k == rst_at) begin rst_n = 1'b0; break; end
        end
        valid_b = 1'b0; valid_m = 1'b0;
    endtask

    // Host-side decode of the recorded trace: bits taken at each clock falling edge.
    task automatic decode(output int lat, output int n_done, output int abort_idx, output int nbits,
                          output logic [10:0] fr0, output logic [10:0] fr1,
                          output logic [7:0] fc0, output logic [7:0] fc1,
                          output int gap, output int n_low);
        logic prev;
        int   last_low1;
        lat = -1; n_done = 0; abort_idx = -1; nbits = 0; gap = -1; n_low = 0; last_low1 = -1;
        fr0 = '0; fr1 = '0; fc0 = 8'h00; fc1 = 8'h00;
        prev = 1'b1;
        for (int i = 0; i < t_clk.size(); i++) begin
            if (t_done[i]) begin
                n_done++;
                if (lat < 0) lat = i + 2;
            end
            if (t_abort[i] && abort_idx < 0) abort_idx = i + 1;
            if (!t_clk[i]) n_low++;
            if (prev && !t_clk[i]) begin
                if (nbits < 11) begin
                    fr0[nbits] = t_data[i];
                    if (nbits == 0) fc0 = t_code[i];
                end else if (nbits < 22) begin
                    fr1[nbits-11] = t_data[i];
                    if (nbits == 11) fc1 = t_code[i];
                end
                nbits++;
            end
            if (!t_clk[i] && n_low == 11*C && last_low1 < 0) last_low1 = i + 1;
            if (last_low1 > 0 && gap < 0 && (i + 1) > last_low1 && !t_data[i])
                gap = i - last_low1;
            prev = t_clk[i];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ps2_clk_i = 1'b1; valid_b = 1'b0; valid_m = 1'b0; hex_in = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b_clk, b_data, b_done, b_abort, b_ready, b_code} !== {5'b11000, 8'h00}) begin
            failures++;
            $display("FAIL reset_b: clk,data,done,abort,ready,code=%b%b%b%b%b %h required 11000 00",
                     b_clk, b_data, b_done, b_abort, b_ready, b_code);
        end
        checks++;
        if ({m_clk, m_data, m_done, m_abort, m_ready, m_code} !== {5'b11000, 8'h00}) begin
            failures++;
            $display("FAIL reset_m: clk,data,done,abort,ready,code=%b%b%b%b%b %h required 11000 00",
                     m_clk, m_data, m_done, m_abort, m_ready, m_code);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({b_ready, m_ready} !== 2'b00) begin
            failures++;
            $display("FAIL ready_first_cycle: ready b,m=%b%b required 00", b_ready, m_ready);
        end
        @(negedge clk);
        checks++;
        if ({b_ready, m_ready, b_clk, b_data, m_clk, m_data} !== 6'b111111) begin
            failures++;
            $display("FAIL ready_second_cycle: ready b,m,lines=%b%b%b%b%b%b required 111111",
                     b_ready, m_ready, b_clk, b_data, m_clk, m_data);
        end
    endtask

    task automatic test_make_break();
        int lat, nd, ai, nb, gap, nl;
        logic [10:0] f0, f1;
        logic [7:0] c0, c1;
        sel_m = 1'b0;
        run_txn(4'h5, 0, 0, 0);
        decode(lat, nd, ai, nb, f0, f1, c0, c1, gap, nl);
        checks++;
        if (f0 !== 11'b11_0000_0110_0 || c0 !== 8'h06) begin
            failures++;
            $display("FAIL mb_make: frame=%b code=%h required %b 06", f0, c0, 11'b11_0000_0110_0);
        end
        checks++;
        if (f1 !== 11'b10_1000_0110_0 || c1 !== 8'h86) begin
            failures++;
            $display("FAIL mb_break: frame=%b code=%h required %b 86", f1, c1, 11'b10_1000_0110_0);
        end
        checks++;
        if (gap != G || nb != 22 || nl != 22*C) begin
            failures++;
            $display("FAIL mb_shape: gap=%0d bits=%0d low=%0d required %0d 22 %0d", gap, nb, nl, G, 22*C);
        end
        checks++;
        if (lat != 1 + 44*C + G + 1 || nd != 1 || ai != -1) begin
            failures++;
            $display("FAIL mb_latency: lat=%0d dones=%0d abort_at=%0d required %0d 1 -1",
                     lat, nd, ai, 1 + 44*C + G + 1);
        end
        checks++;
        if (t_clk[0] !== 1'b1 || t_data[0] !== 1'b0) begin
            failures++;
            $display("FAIL mb_first_cycle: clk,data=%b%b required 10", t_clk[0], t_data[0]);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL mb_after_done: done=%b ready=%b required 0 1", b_done, b_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nd, ai, nb, gap, nl;
        logic [10:0] f0, f1;
        logic [7:0] c0, c1;
        logic [3:0] seq [2] = '{4'hA, 4'h0};
        sel_m = 1'b1;
        for (int r = 0; r < 2; r++) begin
            run_txn(seq[r], 20, 0, 0);
            decode(lat, nd, ai, nb, f0, f1, c0, c1, gap, nl);
            checks++;
            if (f0 !== exp_frame(make_tab[seq[r]]) || c0 !== make_tab[seq[r]] || nb != 11) begin
                failures++;
                $display("FAIL b2b_frame%0d: frame=%b code=%h bits=%0d required %b %h 11",
                         r, f0, c0, nb, exp_frame(make_tab[seq[r]]), make_tab[seq[r]]);
            end
            checks++;
            if (lat != 1 + 22*C + 1 || nd != 1 || nl != 11*C) begin
                failures++;
                $display("FAIL b2b_timing%0d: lat=%0d dones=%0d low=%0d required %0d 1 %0d",
                         r, lat, nd, nl, 1 + 22*C + 1, 11*C);
            end
            @(negedge clk);
            checks++;
            if (m_ready !== 1'b1 || m_done !== 1'b0 || m_clk !== 1'b1) begin
                failures++;
                $display("FAIL b2b_idle%0d: ready=%b done=%b clk=%b required 1 0 1", r, m_ready, m_done, m_clk);
            end
        end
    endtask

    task automatic test_sweep();
        int order [16];
        int j, tmp, lat, nd, ai, nb, gap, nl;
        logic [10:0] f0, f1;
        logic [7:0] c0, c1, mk;
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 0; i < 15; i++) begin
            j = int'($urandom_range(15, i));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        sel_m = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mk = make_tab[order[i]];
            run_txn(4'(order[i]), 0, 0, 0);
            decode(lat, nd, ai, nb, f0, f1, c0, c1, gap, nl);
            checks++;
            if (f0 !== exp_frame(mk) || f1 !== exp_frame(mk | 8'h80) || c0 !== mk || c1 !== (mk | 8'h80)) begin
                failures++;
                $display("FAIL sweep_hex%0h: frames=%b/%b codes=%h/%h required %b/%b %h/%h", order[i],
                         f0, f1, c0, c1, exp_frame(mk), exp_frame(mk | 8'h80), mk, mk | 8'h80);
            end
            checks++;
            if (($countones(f0[9:1]) % 2) != 1 || ($countones(f1[9:1]) % 2) != 1 ||
                lat != 1 + 44*C + G + 1) begin
                failures++;
                $display("FAIL sweep_parity_lat%0h: ones=%0d/%0d lat=%0d required odd/odd %0d", order[i],
                         $countones(f0[9:1]), $countones(f1[9:1]), lat, 1 + 44*C + G + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_inhibit();
        int s, lat, nd, ai, nb, gap, nl, last;
        logic [10:0] f0, f1;
        logic [7:0] c0, c1;
        sel_m = 1'b0;
        s = 8*C + 1 + int'($urandom_range(1, 0));
        run_txn(4'($urandom_range(15, 0)), 0, s, 0);
        decode(lat, nd, ai, nb, f0, f1, c0, c1, gap, nl);
        last = t_clk.size() - 1;
        checks++;
        if (ai != s + 3 || nd != 0) begin
            failures++;
            $display("FAIL inhibit_abort: abort_at=%0d dones=%0d required %0d 0", ai, nd, s + 3);
        end
        checks++;
        if (t_clk[last] !== 1'b1 || t_data[last] !== 1'b1) begin
            failures++;
            $display("FAIL inhibit_release: clk,data=%b%b required 11", t_clk[last], t_data[last]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (b_ready !== 1'b0 || b_abort !== 1'b0 || b_done !== 1'b0 || b_clk !== 1'b1) begin
            failures++;
            $display("FAIL inhibit_hold: ready=%b abort=%b done=%b clk=%b required 0 0 0 1",
                     b_ready, b_abort, b_done, b_clk);
        end
        ps2_clk_i = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("FAIL inhibit_recover: ready=%b required 1", b_ready);
        end
    endtask

    task automatic test_reset_midframe();
        int lat, nd, ai, nb, gap, nl;
        logic [10:0] f0, f1;
        logic [7:0] c0, c1, mk;
        logic [3:0] hx;
        sel_m = 1'b0;
        run_txn(4'($urandom_range(15, 0)), 0, 0, 12*C + C + 2);
        #1;
        checks++;
        if ({b_clk, b_data, b_done, b_abort, b_code} !== {4'b1100, 8'h00}) begin
            failures++;
            $display("FAIL midframe_reset: clk,data,done,abort,code=%b%b%b%b %h required 1100 00",
                     b_clk, b_data, b_done, b_abort, b_code);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        hx = 4'($urandom_range(15, 0));
        mk = make_tab[hx];
        run_txn(hx, 0, 0, 0);
        decode(lat, nd, ai, nb, f0, f1, c0, c1, gap, nl);
        checks++;
        if (f0 !== exp_frame(mk) || f1 !== exp_frame(mk | 8'h80) || lat != 1 + 44*C + G + 1 || nd != 1) begin
            failures++;
            $display("FAIL midframe_recover: frames=%b/%b lat=%0d dones=%0d required %b/%b %0d 1",
                     f0, f1, lat, nd, exp_frame(mk), exp_frame(mk | 8'h80), 1 + 44*C + G + 1);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_back_to_back();
        test_sweep();
        test_inhibit();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
